// File: rtl/usrmux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usrmux_pkg
//  Purpose  : Shared constants and types for the N-channel stream multiplexer.
//             MODE_SELECT / MODE_RR encode the mode input; state_t is the
//             packet-lock state of the arbiter FSM.
//  Revision : 1.0  initial release
// ============================================================================
package usrmux_pkg;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/usrmux_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : usrmux_rr_arb
//  Purpose  : Combinational rotate-priority arbiter. Grants the first
//             requesting channel found scanning i_ptr, i_ptr+1, ... mod NCH.
//  Ports    : i_req     NCH   request per channel
//             i_ptr     SELW  highest-priority channel (must be < NCH)
//             o_gnt     SELW  granted channel (0 when nothing granted)
//             o_gnt_vld 1     a request was found
//  Revision : 1.0  initial release
// ============================================================================
module usrmux_rr_arb #(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  i_req,
    input  logic [SELW-1:0] i_ptr,
    output logic [SELW-1:0] o_gnt,
    output logic            o_gnt_vld
);

    always_comb begin
        int              v_idx;
        logic [SELW-1:0] v_sel;
        o_gnt     = '0;
        o_gnt_vld = 1'b0;
        v_idx     = 0;
        v_sel     = '0;
        // Walk from the farthest offset back toward i_ptr so that the
        // requester nearest the pointer is the one left standing.
        for (int k = NCH - 1; k >= 0; k--) begin
            v_idx = int'(i_ptr) + k;
            if (v_idx >= NCH) begin
                v_idx = v_idx - NCH;
            end
            v_sel = SELW'(v_idx);
            if (i_req[v_sel]) begin
                o_gnt     = v_sel;
                o_gnt_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usrmux_stream_nch.sv
`default_nettype none
// ============================================================================
//  Module   : usrmux_stream_nch
//  Purpose  : NCH-input packet-aware stream multiplexer, valid/ready on both
//             sides, registered output. SELECT mode passes channel sel,
//             ROUND_ROBIN mode rotates between valid channels. A grant is held
//             from the first beat of a packet until its last beat.
//  Ports    : clk, rst (sync, active high)
//             mode, sel                      channel selection control
//             in_valid/in_data/in_last/in_ready   NCH input streams
//             out_valid/out_data/out_last/out_ch/out_ready   output stream
//  Revision : 1.0  initial release
// ============================================================================
module usrmux_stream_nch
    import usrmux_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_last,
    output logic [NCH-1:0]         in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [SELW-1:0]        out_ch,
    input  logic                   out_ready
);

    localparam int c_NPAD = 1 << SELW;

    state_t            r_state;
    logic [SELW-1:0]   r_lock_ch;
    logic [SELW-1:0]   r_rr_ptr;

    logic [SELW-1:0]   w_rr_gnt;
    logic              w_rr_vld;
    logic [SELW-1:0]   w_gnt;
    logic              w_gnt_vld;
    logic              w_adv;
    logic              w_take;
    logic [c_NPAD-1:0] w_valid_pad;
    logic [WIDTH-1:0]  w_gnt_data;
    logic              w_gnt_last;
    logic [SELW-1:0]   w_rr_next;

    usrmux_rr_arb #(
        .NCH (NCH)
    ) u_rr_arb (
        .i_req     (in_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_rr_gnt),
        .o_gnt_vld (w_rr_vld)
    );

    // Pad valid to the full sel range: an out-of-range sel reads a zero and
    // therefore grants nothing.
    always_comb begin
        w_valid_pad          = '0;
        w_valid_pad[NCH-1:0] = in_valid;
    end

    always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_gnt     = r_lock_ch;
            w_gnt_vld = w_valid_pad[r_lock_ch];
        end else if (mode == MODE_SELECT) begin
            w_gnt     = sel;
            w_gnt_vld = w_valid_pad[sel];
        end else begin
            w_gnt     = w_rr_gnt;
            w_gnt_vld = w_rr_vld;
        end
    end

    assign w_adv  = ~out_valid | out_ready;
    assign w_take = w_adv & w_gnt_vld & ~rst;

    // Compare-select mux: only the granted lane can reach the output
    // register, other lanes' data/last never propagate.
    always_comb begin
        w_gnt_data = '0;
        w_gnt_last = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (w_gnt == SELW'(k)) begin
                w_gnt_data = in_data[k*WIDTH +: WIDTH];
                w_gnt_last = in_last[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ready
            assign in_ready[k] = w_take & (w_gnt == SELW'(k));
        end
    endgenerate

    assign w_rr_next = (w_gnt == SELW'(NCH - 1)) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
            r_rr_ptr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else begin
            if (w_adv) begin
                out_valid <= w_take;
                if (w_take) begin
                    out_data <= w_gnt_data;
                    out_last <= w_gnt_last;
                    out_ch   <= w_gnt;
                end
            end
            if (w_take) begin
                if ((r_state == ST_IDLE) && !w_gnt_last) begin
                    r_state   <= ST_LOCKED;
                    r_lock_ch <= w_gnt;
                end else if ((r_state == ST_LOCKED) && w_gnt_last) begin
                    r_state <= ST_IDLE;
                end
                if (w_gnt_last && (mode == MODE_RR)) begin
                    r_rr_ptr <= w_rr_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usrmux_stream_nch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usrmux_stream_nch
//  Purpose  : Self-checking bench for usrmux_stream_nch: vector table,
//             directed multi-cycle sequences, randomized traffic against a
//             packet-level reference model. A second NCH=5 instance covers
//             out-of-range sel.
//  Revision : 1.0  initial release
// ============================================================================
module tb_usrmux_stream_nch;

    localparam int WIDTH  = 64;
    localparam int NCH    = 4;
    localparam int SELW   = 2;
    localparam int WIDTH5 = 8;
    localparam int NCH5   = 5;
    localparam int SELW5  = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH-1:0]       in_valid, in_last, in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_valid, out_last, out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;

    logic                   mode5;
    logic [SELW5-1:0]       sel5;
    logic [NCH5-1:0]        in_valid5, in_last5, in_ready5;
    logic [NCH5*WIDTH5-1:0] in_data5;
    logic                   out_valid5, out_last5, out_ready5;
    logic [WIDTH5-1:0]      out_data5;
    logic [SELW5-1:0]       out_ch5;

    int checks   = 0;
    int failures = 0;

    logic [64:0] exp_q [NCH][$];

    always #5 clk = ~clk;

    usrmux_stream_nch #(.WIDTH(WIDTH), .NCH(NCH)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    usrmux_stream_nch #(.WIDTH(WIDTH5), .NCH(NCH5)) u_dut5 (
        .clk(clk), .rst(rst), .mode(mode5), .sel(sel5),
        .in_valid(in_valid5), .in_data(in_data5), .in_last(in_last5), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_last(out_last5), .out_ch(out_ch5),
        .out_ready(out_ready5)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dword(input int tag, input int ch);
        return {32'(tag), 32'(ch) ^ 32'h5A00_0000};
    endfunction

    task automatic set_beat(input int ch, input logic [63:0] d, input logic last);
        in_data[ch*WIDTH +: WIDTH] = d;
        in_last[ch]                = last;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid  = '0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic pulse_reset();
        in_valid = '0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
    endtask

    // Packet-level traffic: per-channel beat sequences, per-channel
    // expected-output queues, and the grant rules evaluated directly.
    task automatic run_random(input bit rr, input int ncyc);
        int          rem [NCH];
        logic [63:0] cd  [NCH];
        int          lock_m, nxt_in, out_lock, take, g;
        bit          ov_m, adv, drain;
        logic [NCH-1:0] exp_rdy;
        logic [64:0] beat;

        pulse_reset();
        lock_m = -1; nxt_in = 0; out_lock = -1; ov_m = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            rem[ch] = $urandom_range(1, 4);
            cd[ch]  = {$urandom, $urandom};
            exp_q[ch].delete();
        end
        mode = rr;
        for (int c = 0; c < ncyc; c++) begin
            drain = (c >= ncyc - 12);
            if (!rr) sel = SELW'($urandom_range(0, NCH - 1));
            if (drain)   in_valid = '0;
            else if (rr) in_valid = '1;
            else         in_valid = NCH'($urandom_range(0, (1 << NCH) - 1));
            out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            for (int ch = 0; ch < NCH; ch++) set_beat(ch, cd[ch], rem[ch] == 1);

            @(negedge clk);
            check("rand_out_valid", 64'(out_valid), 64'(ov_m));
            adv = !ov_m || out_ready;
            if (lock_m >= 0) g = lock_m;
            else if (rr)     g = nxt_in;
            else             g = int'(sel);
            exp_rdy = (adv && in_valid[g]) ? NCH'(1 << g) : '0;
            check(rr ? "rr_in_ready" : "sel_in_ready", 64'(in_ready), 64'(exp_rdy));

            if (out_valid && out_ready) begin
                if (out_lock >= 0) check("no_interleave", 64'(out_ch), 64'(out_lock));
                if (exp_q[out_ch].size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat: got ch %0d data 0x%0h expected none", out_ch, out_data);
                end else begin
                    beat = exp_q[out_ch].pop_front();
                    check("rand_data", out_data, beat[63:0]);
                    check("rand_last", 64'(out_last), 64'(beat[64]));
                end
                out_lock = out_last ? -1 : int'(out_ch);
            end

            take = -1;
            for (int ch = 0; ch < NCH; ch++) if (in_valid[ch] && in_ready[ch]) take = ch;
            tick();
            if (take >= 0) begin
                exp_q[take].push_back({rem[take] == 1, cd[take]});
                if (rem[take] == 1) begin
                    lock_m = -1;
                    if (rr) nxt_in = (take + 1) % NCH;
                    rem[take] = $urandom_range(1, 4);
                end else begin
                    lock_m = take;
                    rem[take]--;
                end
                cd[take] = {$urandom, $urandom};
            end
            if (adv) ov_m = (take >= 0);
        end
        g = 0;
        for (int ch = 0; ch < NCH; ch++) g += exp_q[ch].size();
        check(rr ? "rr_queue_empty" : "sel_queue_empty", 64'(g), 64'd0);
    endtask

    typedef struct packed {
        logic            mode;
        logic [SELW-1:0] sel;
        logic [NCH-1:0]  valid;
        logic [NCH-1:0]  exp_ready;
        logic            exp_ov;
        logic [SELW-1:0] exp_ch;
    } vec_t;

    vec_t vt [18];

    initial begin
        // Single-beat packets: state stays IDLE, only rr_ptr evolves.
        vt[0]  = '{1'b0, 2'd2, 4'b1111, 4'b0100, 1'b1, 2'd2};
        vt[1]  = '{1'b0, 2'd1, 4'b0101, 4'b0000, 1'b0, 2'd0};
        vt[2]  = '{1'b0, 2'd0, 4'b0001, 4'b0001, 1'b1, 2'd0};
        vt[3]  = '{1'b0, 2'd3, 4'b1000, 4'b1000, 1'b1, 2'd3};
        vt[4]  = '{1'b1, 2'd0, 4'b1111, 4'b0001, 1'b1, 2'd0};
        vt[5]  = '{1'b1, 2'd0, 4'b1111, 4'b0010, 1'b1, 2'd1};
        vt[6]  = '{1'b1, 2'd0, 4'b1111, 4'b0100, 1'b1, 2'd2};
        vt[7]  = '{1'b1, 2'd0, 4'b1111, 4'b1000, 1'b1, 2'd3};
        vt[8]  = '{1'b1, 2'd0, 4'b1111, 4'b0001, 1'b1, 2'd0};
        vt[9]  = '{1'b1, 2'd0, 4'b1011, 4'b0010, 1'b1, 2'd1};
        vt[10] = '{1'b1, 2'd0, 4'b1011, 4'b1000, 1'b1, 2'd3};
        vt[11] = '{1'b1, 2'd0, 4'b1011, 4'b0001, 1'b1, 2'd0};
        vt[12] = '{1'b1, 2'd0, 4'b1011, 4'b0010, 1'b1, 2'd1};
        vt[13] = '{1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vt[14] = '{1'b1, 2'd0, 4'b0001, 4'b0001, 1'b1, 2'd0};
        vt[15] = '{1'b0, 2'd1, 4'b0110, 4'b0010, 1'b1, 2'd1};
        vt[16] = '{1'b1, 2'd0, 4'b1100, 4'b0100, 1'b1, 2'd2};
        vt[17] = '{1'b1, 2'd0, 4'b0111, 4'b0001, 1'b1, 2'd0};

        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '1; in_last = '0; out_ready = 1'b1;
        in_data = '0;
        mode5 = 1'b0; sel5 = '0; in_valid5 = '0; in_last5 = '1; out_ready5 = 1'b1;
        in_data5 = 40'h44_33_22_11_00;
        for (int ch = 0; ch < NCH; ch++) set_beat(ch, {$urandom, $urandom}, 1'b0);

        // Reset held two cycles with every channel valid.
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", 64'(in_ready), 64'd0);
        end
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ch", 64'(out_ch), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        rst = 1'b0; in_valid = '0;
        tick();

        // Vector table.
        in_last = '1;
        for (int r = 0; r < 18; r++) begin
            mode = vt[r].mode; sel = vt[r].sel; in_valid = vt[r].valid;
            for (int ch = 0; ch < NCH; ch++) in_data[ch*WIDTH +: WIDTH] = dword(r, ch);
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", r), 64'(in_ready), 64'(vt[r].exp_ready));
            tick();
            check($sformatf("vec%0d_out_valid", r), 64'(out_valid), 64'(vt[r].exp_ov));
            if (vt[r].exp_ov) begin
                check($sformatf("vec%0d_out_ch", r), 64'(out_ch), 64'(vt[r].exp_ch));
                check($sformatf("vec%0d_out_data", r), out_data, dword(r, int'(vt[r].exp_ch)));
                check($sformatf("vec%0d_out_last", r), 64'(out_last), 64'd1);
            end
        end

        // SELECT sel=2: three-beat packet, one-cycle latency, in order.
        idle_cycle();
        mode = 1'b0; sel = 2'd2; in_valid = '1; in_last = '1;
        for (int b = 0; b < 3; b++) begin
            set_beat(2, dword(100 + b, 2), b == 2);
            @(negedge clk);
            check("sel2_in_ready", 64'(in_ready), 64'b0100);
            tick();
            check("sel2_out_valid", 64'(out_valid), 64'd1);
            check("sel2_out_ch", 64'(out_ch), 64'd2);
            check("sel2_out_data", out_data, dword(100 + b, 2));
            check("sel2_out_last", 64'(out_last), 64'(b == 2));
        end

        // SELECT lock: sel moves to 3 after the first ch1 beat.
        idle_cycle();
        sel = 2'd1; in_valid = 4'b1010;
        set_beat(3, dword(400, 3), 1'b1);
        for (int c = 0; c < 4; c++) begin
            set_beat(1, dword(300 + c, 1), c == 2);
            @(negedge clk);
            check("lock_in_ready", 64'(in_ready), (c < 3) ? 64'b0010 : 64'b1000);
            tick();
            check("lock_out_ch", 64'(out_ch), (c < 3) ? 64'd1 : 64'd3);
            check("lock_out_data", out_data, (c < 3) ? dword(300 + c, 1) : dword(400, 3));
            sel = 2'd3;
        end

        // Backpressure: 5 stall cycles while beat 1 of a 4-beat packet sits in the output.
        idle_cycle();
        begin
            int s, e;
            bit hs;
            s = 0; e = 0;
            sel = 2'd0;
            for (int c = 0; c < 20; c++) begin
                out_ready = !(c >= 2 && c < 7);
                in_valid  = (s < 4) ? 4'b0001 : 4'b0000;
                set_beat(0, dword(200 + s, 0), s == 3);
                @(negedge clk);
                if (!out_ready) begin
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_hold_valid", 64'(out_valid), 64'd1);
                    check("bp_hold_data", out_data, dword(201, 0));
                end
                if (out_valid && out_ready) begin
                    check("bp_data", out_data, dword(200 + e, 0));
                    check("bp_last", 64'(out_last), 64'(e == 3));
                    e++;
                end
                hs = in_valid[0] && in_ready[0];
                tick();
                if (hs) s++;
            end
            check("bp_beats_out", 64'(e), 64'd4);
            check("bp_beats_in", 64'(s), 64'd4);
        end

        // Reset while LOCKED in round-robin: lock and rr_ptr both cleared.
        idle_cycle();
        mode = 1'b1; in_valid = 4'b0100;
        set_beat(2, dword(500, 2), 1'b1);
        @(negedge clk);
        check("rrlock_single", 64'(in_ready), 64'b0100);
        tick();
        set_beat(2, dword(501, 2), 1'b0);
        @(negedge clk);
        check("rrlock_start", 64'(in_ready), 64'b0100);
        tick();
        in_valid = '1; in_last = '0;
        set_beat(2, dword(502, 2), 1'b0);
        @(negedge clk);
        check("rrlock_held", 64'(in_ready), 64'b0100);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rstlock_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        check("rstlock_out_valid", 64'(out_valid), 64'd0);
        check("rstlock_out_ch", 64'(out_ch), 64'd0);
        in_last = '1;
        for (int ch = 0; ch < NCH; ch++) in_data[ch*WIDTH +: WIDTH] = dword(600, ch);
        @(negedge clk);
        check("rstlock_regrant", 64'(in_ready), 64'b0001);
        tick();
        check("rstlock_out_ch0", 64'(out_ch), 64'd0);
        check("rstlock_out_data", out_data, dword(600, 0));
        in_valid = '0;

        // NCH=5: sel beyond the last channel grants nothing.
        sel5 = 3'd7; in_valid5 = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("sel7_in_ready", 64'(in_ready5), 64'd0);
            tick();
            check("sel7_out_valid", 64'(out_valid5), 64'd0);
        end
        sel5 = 3'd4;
        @(negedge clk);
        check("sel4_in_ready", 64'(in_ready5), 64'b10000);
        tick();
        check("sel4_out_ch", 64'(out_ch5), 64'd4);
        check("sel4_out_data", 64'(out_data5), 64'h44);
        in_valid5 = '0;

        run_random(1'b1, 1500);
        run_random(1'b0, 1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
